// File: rtl/alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// alu_exec_ctrl
//   Issue-side controller for a 16-bit combinational ALU. Accepts decoded
//   instructions, reads the operands from an internal register file, and
//   drives registered alu_opcode/alu_a/alu_b. After one settle cycle it
//   captures the ALU result, writes it back to rd, updates the sticky flags
//   and presents the result on a valid/ready result port.
//
// Handshakes (both ports): a transfer happens on the rising clk edge where
//   valid and ready are both 1. A source holds valid (and its payload)
//   stable until that edge. instr_ready is 1 only in IDLE; res_valid and
//   res_* stay stable in WB until res_ready is seen.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   instr_valid/instr_ready       instruction handshake
//   instr_op/rd/rs/rt             opcode, destination, sources (rs->a, rt->b)
//   ld_en/ld_addr/ld_data         direct register-file load, any state
//   alu_opcode/alu_a/alu_b        registered operands to the ALU
//   alu_out/alu_cy/alu_zero       combinational ALU result
//   res_valid/res_ready           result handshake
//   res_data/res_cy/res_zero      result payload
//   flag_cy/flag_zero             flags of the last completed instruction
//   dbg_state                     FSM state (0 IDLE, 1 EXEC, 2 WB)
// ---------------------------------------------------------------------------
module alu_exec_ctrl #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [2:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cy,
  input  logic          alu_zero,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_cy,
  output logic          res_zero,
  output logic          flag_cy,
  output logic          flag_zero,
  output logic [1:0]    dbg_state
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [AW-1:0] rd_q, rd_d;
  logic [2:0]    alu_opcode_q, alu_opcode_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_cy_q, res_cy_d;
  logic          res_zero_q, res_zero_d;
  logic          flag_cy_q, flag_cy_d;
  logic          flag_zero_q, flag_zero_d;

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_cy_d     = res_cy_q;
    res_zero_d   = res_zero_q;
    flag_cy_d    = flag_cy_q;
    flag_zero_d  = flag_zero_q;
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];

    // Direct load first, so a write-back to the same register below overrides it.
    if (ld_en) regs_d[ld_addr] = ld_data;

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          // Operands come from regs_q: a load on this same edge is not forwarded.
          alu_opcode_d = instr_op;
          alu_a_d      = regs_q[instr_rs];
          alu_b_d      = regs_q[instr_rt];
          rd_d         = instr_rd;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        res_data_d    = alu_out;
        res_cy_d      = alu_cy;
        res_zero_d    = alu_zero;
        regs_d[rd_q]  = alu_out;
        flag_cy_d     = alu_cy;
        flag_zero_d   = alu_zero;
        res_valid_d   = 1'b1;
        state_d       = S_WB;
      end
      S_WB: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_q         <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_cy_q     <= 1'b0;
      res_zero_q   <= 1'b0;
      flag_cy_q    <= 1'b0;
      flag_zero_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_cy_q     <= res_cy_d;
      res_zero_q   <= res_zero_d;
      flag_cy_q    <= flag_cy_d;
      flag_zero_q  <= flag_zero_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_cy      = res_cy_q;
  assign res_zero    = res_zero_q;
  assign flag_cy     = flag_cy_q;
  assign flag_zero   = flag_zero_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_ctrl
//   Bench for alu_exec_ctrl. Provides the combinational ALU, a register-file
//   reference model, a directed vector table, hand-written corner sequences
//   (stall, load collisions, reset mid-instruction) and a randomized run.
// ---------------------------------------------------------------------------
module tb_alu_exec_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [2:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0, instr_rs = '0, instr_rt = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic          alu_cy, alu_zero;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_cy, res_zero, flag_cy, flag_zero;
  logic [1:0]    dbg_state;

  alu_exec_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cy(alu_cy), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cy(res_cy), .res_zero(res_zero),
    .flag_cy(flag_cy), .flag_zero(flag_zero), .dbg_state(dbg_state)
  );

  // ---------------- ALU: (DW+1)-bit result from the opcode rules ----------------
  function automatic logic [DW:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW:0] ax, bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (op)
      3'd0:    return ax + bx;
      3'd1:    return ax - bx;          // bit DW is the borrow
      3'd2:    return ax & bx;
      3'd3:    return ax | bx;
      3'd4:    return ax ^ bx;
      3'd5:    return {1'b1, ~a};
      3'd6:    return {1'b0, a >> b};
      default: return ax << b;          // bit DW is the bit shifted out
    endcase
  endfunction

  logic [DW:0] alu_res;
  always_comb alu_res = alu_f(alu_opcode, alu_a, alu_b);
  assign alu_out  = alu_res[DW-1:0];
  assign alu_cy   = alu_res[DW];
  assign alu_zero = (alu_res[DW-1:0] == '0);

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] model_regs [8];
  logic          model_cy = 1'b0, model_zero = 1'b0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   last_res;
  logic [AW-1:0] pend_rd;
  logic [2:0]    pend_op;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    tick();
    ld_en = 1'b0;
    model_regs[addr] = data;
  endtask

  // Offer one instruction and complete the accept edge.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] rd,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    int n;
    n = 0;
    while (!instr_ready && n < 16) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(instr_ready), 32'd1);
    exp_q.push_back(alu_f(op, model_regs[rs], model_regs[rt]));
    pend_rd = rd;
    pend_op = op;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    tick();
    instr_valid = 1'b0;
    check("accept_res_valid", 32'(res_valid), 32'd0);
    check("accept_instr_ready", 32'(instr_ready), 32'd0);
    check("accept_opcode", 32'(alu_opcode), 32'(op));
  endtask

  // Settle edge: result must appear now, one edge after the accept edge.
  task automatic exec_edge();
    logic [DW:0] e;
    tick();
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    last_res = e;
    model_regs[pend_rd] = e[DW-1:0];
    model_cy   = e[DW];
    model_zero = (e[DW-1:0] == '0);
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_data", 32'(res_data), 32'(e[DW-1:0]));
    check("res_cy", 32'(res_cy), 32'(e[DW]));
    check("res_zero", 32'(res_zero), 32'(model_zero));
    check("flag_cy", 32'(flag_cy), 32'(model_cy));
    check("flag_zero", 32'(flag_zero), 32'(model_zero));
  endtask

  // Hold res_ready low for 'stall' cycles (optionally offering a competing
  // instruction), then accept the result.
  task automatic release_res(input int stall, input bit poke);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        instr_valid = 1'b1;
        instr_op = 3'($urandom_range(0, 7));
        instr_rd = 3'($urandom_range(0, 7));
        instr_rs = 3'($urandom_range(0, 7));
        instr_rt = 3'($urandom_range(0, 7));
      end
      tick();
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_res_data", 32'(res_data), 32'(last_res[DW-1:0]));
      check("stall_instr_ready", 32'(instr_ready), 32'd0);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("release_res_valid", 32'(res_valid), 32'd0);
    check("release_instr_ready", 32'(instr_ready), 32'd1);
    check("release_opcode_held", 32'(alu_opcode), 32'(pend_op));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'($urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] d;
    logic          cy;
    logic          z;
  } vec_t;
  vec_t vecs[12];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [AW-1:0] rd, rs, rt, la;
    logic [2:0]    op;
    logic [DW-1:0] ld;
    bit            acc_ld, exe_ld;

    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0};
    vecs[2]  = '{3'd5, 16'h00FF, 16'h1234, 16'hFF00, 1'b1, 1'b0};
    vecs[3]  = '{3'd7, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[4]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{3'd6, 16'h8001, 16'h0001, 16'h4000, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{3'd7, 16'h4001, 16'h0001, 16'h8002, 1'b0, 1'b0};
    vecs[11] = '{3'd7, 16'h00FF, 16'h0004, 16'h0FF0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) model_regs[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr_ready", 32'(instr_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_flags", 32'({flag_cy, flag_zero, res_cy, res_zero}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table: R1=a, R2=b, op rd=3; then read R3 back with or R3,R3
    foreach (vecs[i]) begin
      do_load(3'd1, vecs[i].a);
      do_load(3'd2, vecs[i].b);
      send(vecs[i].op, 3'd3, 3'd1, 3'd2);
      exec_edge();
      check("vec_data", 32'(res_data), 32'(vecs[i].d));
      check("vec_cy", 32'(res_cy), 32'(vecs[i].cy));
      check("vec_zero", 32'(res_zero), 32'(vecs[i].z));
      release_res(0, 1'b0);
      send(3'd3, 3'd5, 3'd3, 3'd3);
      exec_edge();
      check("vec_writeback", 32'(res_data), 32'(vecs[i].d));
      release_res(0, 1'b0);
    end

    // Result stall with a competing instruction offered
    do_load(3'd1, 16'h0010);
    do_load(3'd2, 16'h0020);
    send(3'd0, 3'd4, 3'd1, 3'd2);
    exec_edge();
    release_res(5, 1'b1);
    tick();
    check("stall_no_extra_accept", 32'(res_valid), 32'd0);
    check("stall_state_idle", 32'(instr_ready), 32'd1);

    // Load to rs on the accept edge: operand uses the old value
    do_load(3'd1, 16'h0005);
    do_load(3'd2, 16'h0003);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0100;
    send(3'd0, 3'd4, 3'd1, 3'd2);
    ld_en = 1'b0;
    model_regs[1] = 16'h0100;
    exec_edge();
    check("acc_ld_old_operand", 32'(res_data), 32'h0008);
    release_res(0, 1'b0);
    send(3'd3, 3'd5, 3'd1, 3'd1);
    exec_edge();
    check("acc_ld_reg_written", 32'(res_data), 32'h0100);
    release_res(0, 1'b0);

    // Load to rd on the write-back edge: write-back wins
    send(3'd0, 3'd4, 3'd1, 3'd2);
    ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'hBEEF;
    exec_edge();
    ld_en = 1'b0;
    release_res(0, 1'b0);
    send(3'd3, 3'd6, 3'd4, 3'd4);
    exec_edge();
    check("exec_ld_wb_wins", 32'(res_data), 32'h0103);
    release_res(0, 1'b0);

    // Reset during EXEC
    do_load(3'd1, 16'hFFFF);
    send(3'd0, 3'd3, 3'd1, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_flags", 32'({flag_cy, flag_zero}), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    check("mid_rst_res_data", 32'(res_data), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    model_cy = 1'b0;
    model_zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_instr_ready", 32'(instr_ready), 32'd1);
    send(3'd3, 3'd5, 3'd1, 3'd3);
    exec_edge();
    check("post_rst_regs_zero", 32'({res_data, res_zero}), 32'h1);
    release_res(0, 1'b0);

    // Randomized run against the model
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(3'($urandom_range(0, 7)), rnd_data());
      end else begin
        op = 3'($urandom_range(0, 7));
        rd = 3'($urandom_range(0, 7));
        rs = 3'($urandom_range(0, 7));
        rt = 3'($urandom_range(0, 7));
        acc_ld = ($urandom_range(0, 3) == 0);
        exe_ld = ($urandom_range(0, 3) == 0);
        if (acc_ld) begin
          la = 3'($urandom_range(0, 7));
          ld = rnd_data();
          ld_en = 1'b1; ld_addr = la; ld_data = ld;
        end
        send(op, rd, rs, rt);
        ld_en = 1'b0;
        if (acc_ld) model_regs[la] = ld;
        if (exe_ld) begin
          la = ($urandom_range(0, 1) == 0) ? rd : 3'($urandom_range(0, 7));
          ld = rnd_data();
          ld_en = 1'b1; ld_addr = la; ld_data = ld;
        end
        exec_edge();
        ld_en = 1'b0;
        if (exe_ld && la != rd) model_regs[la] = ld;
        release_res($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
